// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader
//   Reads one stored frame of H_WORDS x V_LINES 16-bit words out of SDRAM by
//   issuing fixed-length burst requests to the read arbiter. Returned words
//   go into a small first-word-fall-through FIFO. They leave as a
//   valid/ready pixel stream with sof/eol/eof markers. A burst is requested
//   only when the FIFO has room for all of its words, so returned data is
//   never dropped.
//
// Ports
//   sclk, srst          clock and synchronous active-high reset
//   start / busy        frame request pulse / frame in progress
//   frame_done          one-cycle pulse after the last word is accepted
//   rd_req / rd_ack     burst request and its one-cycle grant
//   rd_bank/row/col     start address of the requested burst
//   rd_data_vld/rd_data returned read words
//   pix_*               output stream (valid/ready, data, markers)
//   err_ovf             sticky flag for unexpected returned data
module sdram_frame_reader #(
  parameter int H_WORDS    = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        rd_req,
  input  logic        rd_ack,
  output logic [1:0]  rd_bank,
  output logic [11:0] rd_row,
  output logic [8:0]  rd_col,
  input  logic        rd_data_vld,
  input  logic [15:0] rd_data,
  output logic        pix_vld,
  input  logic        pix_rdy,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        err_ovf
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam logic [22:0]     BASE       = 23'(BASE_ADDR);
  localparam logic [22:0]     TOTAL      = 23'(H_WORDS * V_LINES);
  localparam logic [22:0]     BURST_STEP = 23'(BURST_LEN);
  localparam logic [AW:0]     BURST_CNT  = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]     DEPTH      = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW+1:0]   USED_MAX   = (AW+2)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [15:0]     COL_LAST   = 16'(H_WORDS - 1);
  localparam logic [15:0]     LINE_LAST  = 16'(V_LINES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    state;
  logic [22:0]   req_cnt;
  logic [22:0]   addr;
  logic [AW:0]   outstanding;
  logic [AW:0]   fifo_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [15:0]   col;
  logic [15:0]   line;
  logic          eof_seen;

  logic [AW+1:0] used;
  logic          credit_ok;
  logic          all_issued;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          bad_word;
  logic          done_now;
  logic          accept_start;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    used         = {1'b0, fifo_count} + {1'b0, outstanding};
    credit_ok    = (used <= USED_MAX);
    all_issued   = (req_cnt == TOTAL);
    fifo_full    = (fifo_count == DEPTH);
    pop          = pix_vld && pix_rdy;
    // A full FIFO can still take a word in the same cycle one leaves.
    push         = rd_data_vld && (state == S_DATA) && (outstanding != '0) &&
                   (!fifo_full || pop);
    bad_word     = rd_data_vld && !push;
    done_now     = (state == S_DRAIN) && (fifo_count == '0) && eof_seen;
    accept_start = (state == S_IDLE) && start;
  end

  // Address outputs are held at zero outside a request so that idle and reset show all-zero outputs.
  assign addr       = BASE + req_cnt;
  assign rd_req     = (state == S_REQ);
  assign rd_bank    = rd_req ? addr[22:21] : 2'd0;
  assign rd_row     = rd_req ? addr[20:9]  : 12'd0;
  assign rd_col     = rd_req ? addr[8:0]   : 9'd0;
  assign busy       = (state != S_IDLE);
  assign frame_done = done_now;

  assign pix_vld  = (fifo_count != '0);
  assign pix_data = pix_vld ? mem[rd_ptr] : 16'd0;
  assign pix_sof  = pix_vld && (col == 16'd0) && (line == 16'd0);
  assign pix_eol  = pix_vld && (col == COL_LAST);
  assign pix_eof  = pix_eol && (line == LINE_LAST);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge sclk) begin
    if (srst) begin
      state       <= S_IDLE;
      req_cnt     <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_REQ;
            req_cnt <= '0;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            outstanding <= outstanding + BURST_CNT;
            req_cnt     <= req_cnt + BURST_STEP;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (push) outstanding <= outstanding - 1'b1;
          if (outstanding == '0) begin
            if (all_issued)     state <= S_DRAIN;
            else if (credit_ok) state <= S_REQ;
            else                state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (credit_ok) state <= S_REQ;
        end
        S_DRAIN: begin
          if (done_now) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output position counters and end-of-frame tracking; restarted by each accepted start.
  always_ff @(posedge sclk) begin
    if (srst || accept_start) begin
      col      <= '0;
      line     <= '0;
      eof_seen <= 1'b0;
    end else if (pop) begin
      if (pix_eof) eof_seen <= 1'b1;
      if (col == COL_LAST) begin
        col  <= '0;
        line <= (line == LINE_LAST) ? 16'd0 : line + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sclk) begin
    if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only visible while fifo_count says a word is valid.
  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  always_ff @(posedge sclk) begin
    if (srst)          err_ovf <= 1'b0;
    else if (bad_word) err_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
module tb_sdram_frame_reader;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int BASE  = 508;
  localparam int BL    = 4;
  localparam int DEPTH = 16;
  localparam int TOTAL = H * V;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic        start = 1'b0;
  logic        rd_ack = 1'b0;
  logic        resp_vld = 1'b0;
  logic        spur_vld = 1'b0;
  logic        rd_data_vld;
  logic [15:0] rd_data = 16'd0;
  logic        pix_rdy = 1'b0;
  logic        busy, frame_done, rd_req, pix_vld, pix_sof, pix_eol, pix_eof, err_ovf;
  logic [1:0]  rd_bank;
  logic [11:0] rd_row;
  logic [8:0]  rd_col;
  logic [15:0] pix_data;

  assign rd_data_vld = resp_vld | spur_vld;

  always #5 sclk = ~sclk;

  sdram_frame_reader #(
    .H_WORDS(H), .V_LINES(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .sclk(sclk), .srst(srst), .start(start), .busy(busy), .frame_done(frame_done),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .err_ovf(err_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Model state: word index expected next at the output, plus bookkeeping.
  int          idx = 0;
  int          xfer = 0;
  int          acked = 0;
  int          burst_idx = 0;
  int          done_cnt = 0;
  int          eol_cnt = 0;
  bit          mon_en = 1'b0;
  bit          abort = 1'b0;
  bit          resp_in_data = 1'b0;
  bit          eof_prev = 1'b0;
  logic [22:0] burst_addr [4];
  logic [15:0] first_word = 16'd0;
  logic [15:0] last_word = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    idx = 0; xfer = 0; acked = 0; burst_idx = 0;
    done_cnt = 0; eol_cnt = 0; eof_prev = 1'b0;
    first_word = 16'd0; last_word = 16'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_rd_req"},     32'(rd_req),     0);
    check({tag, "_rd_addr"},    32'({rd_bank, rd_row, rd_col}), 0);
    check({tag, "_pix_vld"},    32'(pix_vld),    0);
    check({tag, "_pix_data"},   32'(pix_data),   0);
    check({tag, "_markers"},    32'({pix_sof, pix_eol, pix_eof}), 0);
    check({tag, "_err_ovf"},    32'(err_ovf),    0);
  endtask

  // SDRAM read arbiter: grant after three cycles of request, then return
  // BL words whose data is the low 16 bits of their word address.
  initial begin : responder
    logic [22:0] a;
    forever begin
      @(posedge sclk); #1;
      if (rd_req) begin
        a = {rd_bank, rd_row, rd_col};
        check("req_addr", 32'(a), 32'(BASE + burst_idx * BL));
        check("req_credit", 32'((acked - xfer) <= (DEPTH - BL)), 1);
        if (burst_idx < 4) burst_addr[burst_idx] = a;
        repeat (2) begin
          @(posedge sclk); #1;
          check("req_hold", 32'({rd_req, rd_bank, rd_row, rd_col}), 32'({1'b1, a}));
        end
        rd_ack = 1'b1;
        acked += BL;
        burst_idx++;
        check("burst_limit", 32'((acked - xfer) <= DEPTH), 1);
        @(posedge sclk); #1;
        rd_ack = 1'b0;
        check("req_drop", 32'(rd_req), 0);
        resp_in_data = 1'b1;
        for (int i = 0; i < BL; i++) begin
          resp_vld = !abort;
          rd_data  = 16'(a + 23'(i));
          @(posedge sclk); #1;
        end
        resp_vld = 1'b0;
        resp_in_data = 1'b0;
      end
    end
  end

  // Output model: word k of the frame is (BASE+k)[15:0]; markers follow from k.
  initial begin : monitor
    forever begin
      @(negedge sclk);
      if (mon_en) begin
        check("frame_done", 32'(frame_done), 32'(eof_prev));
        if (frame_done) done_cnt++;
        eof_prev = 1'b0;
        check("err_ovf", 32'(err_ovf), 0);
        if (pix_vld) begin
          check("pix_overrun", 32'(idx < TOTAL), 1);
          check("pix_data", 32'(pix_data), 32'(16'(BASE + idx)));
          check("pix_sof", 32'(pix_sof), 32'(idx == 0));
          check("pix_eol", 32'(pix_eol), 32'((idx % H) == (H - 1)));
          check("pix_eof", 32'(pix_eof), 32'(idx == TOTAL - 1));
          if (pix_rdy) begin
            if (idx == 0) first_word = pix_data;
            if (idx == TOTAL - 1) begin
              last_word = pix_data;
              eof_prev  = 1'b1;
            end
            if (pix_eol) eol_cnt++;
            idx++;
            xfer++;
          end
        end
      end
    end
  end

  task automatic do_reset(input string tag);
    @(posedge sclk); #2;
    srst = 1'b1; mon_en = 1'b0; abort = 1'b1; pix_rdy = 1'b0;
    @(posedge sclk);
    @(negedge sclk);
    check_all_zero(tag);
    @(posedge sclk); #2;
    srst = 1'b0;
    repeat (8) @(posedge sclk);
    #2;
    abort = 1'b0;
    clear_model();
  endtask

  task automatic start_frame();
    @(posedge sclk); #1; start = 1'b1;
    @(posedge sclk); #1; start = 1'b0;
    @(negedge sclk);
    check("start_busy", 32'(busy), 1);
    check("start_rd_req", 32'(rd_req), 1);
  endtask

  task automatic wait_xfer(input int n, input bit need_data);
    int c;
    c = 0;
    while (!(xfer >= n && (resp_in_data || !need_data)) && c < 3000) begin
      @(negedge sclk);
      c++;
    end
    check("wait_xfer_timeout", 32'(c < 3000), 1);
  endtask

  task automatic wait_done(input bit toggle_rdy);
    int c;
    c = 0;
    while (done_cnt < 1 && c < 5000) begin
      @(posedge sclk); #1;
      if (toggle_rdy) pix_rdy = ((c % 4) != 3);
      c++;
    end
    pix_rdy = 1'b1;
    check("frame_done_timeout", 32'(done_cnt >= 1), 1);
  endtask

  task automatic frame_summary(input string tag);
    repeat (20) @(negedge sclk);
    check({tag, "_done_cnt"}, 32'(done_cnt), 1);
    check({tag, "_words"},    32'(idx), TOTAL);
    check({tag, "_eols"},     32'(eol_cnt), V);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_rd_req"},   32'(rd_req), 0);
    check({tag, "_first"},    32'(first_word), 508);
    check({tag, "_last"},     32'(last_word), 635);
  endtask

  initial begin : watchdog
    #300000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    repeat (3) @(posedge sclk);
    #1 srst = 1'b0;
    @(negedge sclk);
    check_all_zero("reset");

    // Spurious return data while idle: flagged, sticky, never buffered.
    @(posedge sclk); #1; spur_vld = 1'b1; rd_data = 16'hBEEF;
    @(posedge sclk); #1; spur_vld = 1'b0;
    @(negedge sclk);
    check("spur_err_set", 32'(err_ovf), 1);
    check("spur_fifo_empty", 32'(pix_vld), 0);
    repeat (5) @(negedge sclk);
    check("spur_err_sticky", 32'(err_ovf), 1);
    check("spur_fifo_still_empty", 32'(pix_vld), 0);
    do_reset("spur_clear");

    // Nominal frame across a row boundary, with a start pulse while busy.
    clear_model();
    mon_en = 1'b1; pix_rdy = 1'b1;
    start_frame();
    wait_xfer(30, 1'b0);
    @(posedge sclk); #1; start = 1'b1;
    @(posedge sclk); #1; start = 1'b0;
    wait_done(1'b0);
    frame_summary("nominal");
    check("burst0_row", 32'(burst_addr[0][20:9]), 0);
    check("burst0_col", 32'(burst_addr[0][8:0]), 508);
    check("burst1_row", 32'(burst_addr[1][20:9]), 1);
    check("burst1_col", 32'(burst_addr[1][8:0]), 0);
    check("burst2_col", 32'(burst_addr[2][8:0]), 4);
    check("burst3_col", 32'(burst_addr[3][8:0]), 8);
    check("burst_bank", 32'(burst_addr[3][22:21]), 0);

    // Backpressure: a 100-cycle stall fills the buffer and stops requests.
    clear_model();
    pix_rdy = 1'b1;
    start_frame();
    wait_xfer(40, 1'b0);
    @(posedge sclk); #1; pix_rdy = 1'b0;
    repeat (100) @(posedge sclk);
    @(negedge sclk);
    check("stall_rd_req_low", 32'(rd_req), 0);
    check("stall_buffer_full", 32'(((acked - xfer) > (DEPTH - BL)) && ((acked - xfer) <= DEPTH)), 1);
    check("stall_pix_vld", 32'(pix_vld), 1);
    check("stall_head", 32'(pix_data), 32'(16'(BASE + xfer)));
    wait_done(1'b1);
    frame_summary("backpressure");

    // Reset in the middle of a burst, then a clean frame from the base address.
    clear_model();
    pix_rdy = 1'b1;
    start_frame();
    wait_xfer(40, 1'b1);
    do_reset("midreset");
    mon_en = 1'b1; pix_rdy = 1'b1;
    start_frame();
    wait_done(1'b0);
    frame_summary("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
